// File: rtl/memref_port_arbiter_if.sv
// Requester-side and memory-side signals of the shared memref port.
// The arbiter takes the slave view; the kernels plus memory model together form the master view.
interface memref_port_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 64,
    parameter int NREQ  = 2,
    parameter int AW    = $clog2(SIZE)
);
    logic [NREQ-1:0]            req_en;
    logic [NREQ-1:0]            req_wr;
    logic [NREQ-1:0][AW-1:0]    req_addr;
    logic [NREQ-1:0][WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]            gnt;
    logic [NREQ-1:0]            rsp_valid;
    logic [WIDTH-1:0]           rsp_data;
    logic [AW-1:0]              mem_addr;
    logic                       mem_rd_en;
    logic                       mem_wr_en;
    logic [WIDTH-1:0]           mem_wr_data;
    logic [WIDTH-1:0]           mem_rd_data;
    logic [15:0]                conflict_cnt;

    modport master (
        output req_en, req_wr, req_addr, req_wdata, mem_rd_data,
        input  gnt, rsp_valid, rsp_data, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
               conflict_cnt
    );

    modport slave (
        input  req_en, req_wr, req_addr, req_wdata, mem_rd_data,
        output gnt, rsp_valid, rsp_data, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
               conflict_cnt
    );
endinterface

// File: rtl/memref_port_arbiter.sv
// Round-robin arbiter sharing one single-port memref (1-cycle registered read) among
// NREQ requesters; read data is steered back by a 1-deep per-requester tag.

module memref_port_arbiter_lane (
    input  logic clk,
    input  logic rst,
    input  logic acc_rd,
    output logic rsp_vld
);
    logic [1:0] vld_pipe;

    assign vld_pipe[0] = acc_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe[1] <= 1'b0;
        else     vld_pipe[1] <= vld_pipe[0];
    end

    assign rsp_vld = vld_pipe[1];
endmodule

module memref_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 64,
    parameter int AW    = $clog2(SIZE),
    parameter int NREQ  = 2
) (
    input logic                 clk,
    input logic                 rst,
    memref_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   win;
    logic            win_vld;
    logic [NREQ-1:0] rsp_vld;
    logic [15:0]     cnt;
    logic            multi;

    // Search starts one past the last winner so a held request waits at most NREQ-1 cycles.
    always_comb begin
        int idx;
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!win_vld && bus.req_en[PW'(idx)]) begin
                win_vld = 1'b1;
                win     = PW'(idx);
            end
        end
        if (rst) win_vld = 1'b0;
    end

    always_comb begin
        bus.gnt         = '0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_wr_en   = 1'b0;
        if (win_vld) begin
            bus.gnt[win]    = 1'b1;
            bus.mem_addr    = bus.req_addr[win];
            bus.mem_wr_data = bus.req_wdata[win];
            bus.mem_rd_en   = !bus.req_wr[win];
            bus.mem_wr_en   = bus.req_wr[win];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rr_ptr <= PW'(NREQ - 1);
        else if (win_vld) rr_ptr <= win;
    end

    assign multi = $countones(bus.req_en) > 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         cnt <= '0;
        else if (multi && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        memref_port_arbiter_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .acc_rd  (bus.gnt[i] & ~bus.req_wr[i]),
            .rsp_vld (rsp_vld[i])
        );
    end

    assign bus.rsp_valid    = rsp_vld;
    assign bus.rsp_data     = bus.mem_rd_data;
    assign bus.conflict_cnt = cnt;
endmodule

// File: tb/tb_memref_port_arbiter.sv
// Directed + randomized bench for memref_port_arbiter: NREQ=2 instance with a shadow
// memory/grant model, NREQ=3 instance for fairness and counter saturation.
module tb_memref_port_arbiter;
    logic clk = 1'b0;
    logic rst, rst_b, init;
    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    memref_port_arbiter_if #(.WIDTH(32), .SIZE(64), .NREQ(2), .AW(6)) ifa ();
    memref_port_arbiter_if #(.WIDTH(32), .SIZE(64), .NREQ(3), .AW(6)) ifb ();

    memref_port_arbiter #(.WIDTH(32), .SIZE(64), .AW(6), .NREQ(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    memref_port_arbiter #(.WIDTH(32), .SIZE(64), .AW(6), .NREQ(3)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb.slave));

    // Memory attached to instance A: registered read, write on posedge.
    logic [31:0] mem_a [64];
    logic [31:0] rd_a, rd_b;
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= 32'(i + 1);
        end else begin
            if (ifa.mem_wr_en) mem_a[ifa.mem_addr] <= ifa.mem_wr_data;
            if (ifa.mem_rd_en) rd_a <= mem_a[ifa.mem_addr];
        end
    end
    assign ifa.mem_rd_data = rd_a;

    always @(posedge clk) if (ifb.mem_rd_en) rd_b <= 32'(ifb.mem_addr);
    assign ifb.mem_rd_data = rd_b;

    // Reference model state
    logic [31:0] ref_mem [64];
    int a_last, a_pend, a_cnt, a_wprev;
    logic [31:0] a_pdata;
    int b_last, b_pend, b_cnt;
    int tally [3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rotating priority: first requesting index after the previous winner.
    function automatic int pick(input logic [3:0] en, input int last, input int n);
        for (int k = 1; k <= n; k++) begin
            int i;
            i = (last + k) % n;
            if (en[i[1:0]]) return i;
        end
        return -1;
    endfunction

    task automatic cyc_a();
        int w;
        int ad;
        @(negedge clk);
        if (rst) begin
            chk("rst_gnt", 64'(ifa.gnt), 0);
            chk("rst_rden", 64'(ifa.mem_rd_en), 0);
            chk("rst_wren", 64'(ifa.mem_wr_en), 0);
            chk("rst_addr", 64'(ifa.mem_addr), 0);
            chk("rst_rspv", 64'(ifa.rsp_valid), 0);
            chk("rst_cnt", 64'(ifa.conflict_cnt), 0);
            a_last = 1; a_pend = -1; a_cnt = 0; a_wprev = -1;
        end else begin
            w = pick(4'(ifa.req_en), a_last, 2);
            chk("gnt", 64'(ifa.gnt), (w < 0) ? 64'd0 : (64'd1 << w));
            chk("rd_en", 64'(ifa.mem_rd_en), 64'(w >= 0 && !ifa.req_wr[w[0]]));
            chk("wr_en", 64'(ifa.mem_wr_en), 64'(w >= 0 && ifa.req_wr[w[0]]));
            chk("maddr", 64'(ifa.mem_addr), (w < 0) ? 64'd0 : 64'(ifa.req_addr[w[0]]));
            chk("mwdata", 64'(ifa.mem_wr_data), (w < 0) ? 64'd0 : 64'(ifa.req_wdata[w[0]]));
            chk("rspv", 64'(ifa.rsp_valid), (a_pend < 0) ? 64'd0 : (64'd1 << a_pend));
            if (a_pend >= 0) chk("rsp_data", 64'(ifa.rsp_data), 64'(a_pdata));
            chk("cnt", 64'(ifa.conflict_cnt), 64'(a_cnt));
            if ($countones(ifa.req_en) >= 2 && a_cnt < 65535) a_cnt++;
            a_pend = -1;
            if (w >= 0) begin
                a_last = w;
                ad = int'(ifa.req_addr[w[0]]);
                if (ifa.req_wr[w[0]]) ref_mem[ad] = ifa.req_wdata[w[0]];
                else begin a_pend = w; a_pdata = ref_mem[ad]; end
            end
            a_wprev = w;
        end
        @(posedge clk); #1;
    endtask

    task automatic cyc_b();
        int w;
        @(negedge clk);
        w = pick(4'(ifb.req_en), b_last, 3);
        chk("b_gnt", 64'(ifb.gnt), (w < 0) ? 64'd0 : (64'd1 << w));
        chk("b_rspv", 64'(ifb.rsp_valid), (b_pend < 0) ? 64'd0 : (64'd1 << b_pend));
        chk("b_cnt", 64'(ifb.conflict_cnt), 64'(b_cnt));
        for (int i = 0; i < 3; i++) if (ifb.gnt[i]) tally[i]++;
        if ($countones(ifb.req_en) >= 2) b_cnt++;
        b_pend = -1;
        if (w >= 0) begin
            b_last = w;
            if (!ifb.req_wr[w[1:0]]) b_pend = w;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1; init = 1'b1;
        ifa.req_en = '0; ifa.req_wr = '0; ifa.req_addr = '0; ifa.req_wdata = '0;
        ifb.req_en = '0; ifb.req_wr = '0; ifb.req_addr = '0; ifb.req_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i + 1);
        a_last = 1; a_pend = -1; a_cnt = 0; a_wprev = -1;
        repeat (2) @(posedge clk);
        #1 init = 1'b0;

        // reset state, then single requester streaming reads of addr 5
        ifa.req_en = 2'b11;
        cyc_a();
        rst = 1'b0;
        ifa.req_en = 2'b01; ifa.req_wr = 2'b00; ifa.req_addr[0] = 6'd5;
        repeat (10) cyc_a();
        chk("t2_rspv", 64'(ifa.rsp_valid), 64'h1);
        chk("t2_data", 64'(ifa.rsp_data), 64'd6);
        ifa.req_en = 2'b00;
        cyc_a();

        // reset with a read in flight: response must vanish and never reappear
        ifa.req_en = 2'b01; ifa.req_addr[0] = 6'd9;
        cyc_a();
        rst = 1'b1;
        #1 chk("t1_flush", 64'(ifa.rsp_valid), 0);
        ifa.req_en = 2'b11;
        repeat (2) cyc_a();
        rst = 1'b0; ifa.req_en = 2'b00;
        repeat (2) cyc_a();

        // contention: alternating grants, counter counts every contended cycle
        ifa.req_en = 2'b11; ifa.req_wr = 2'b00;
        ifa.req_addr[0] = 6'd1; ifa.req_addr[1] = 6'd2;
        repeat (6) cyc_a();
        chk("t3_cnt", 64'(ifa.conflict_cnt), 64'd6);
        ifa.req_en = 2'b00;
        cyc_a();

        // mixed read/write and read-after-write
        ifa.req_en = 2'b11; ifa.req_wr = 2'b10;
        ifa.req_addr[0] = 6'd7; ifa.req_addr[1] = 6'd3; ifa.req_wdata[1] = 32'hDEAD;
        cyc_a();
        ifa.req_en = 2'b10;
        cyc_a();
        ifa.req_en = 2'b01; ifa.req_wr = 2'b00; ifa.req_addr[0] = 6'd3;
        cyc_a();
        chk("t4_rspv", 64'(ifa.rsp_valid), 64'h1);
        chk("t4_raw", 64'(ifa.rsp_data), 64'hDEAD);
        ifa.req_en = 2'b00;
        cyc_a();

        // randomized traffic; a losing request is held stable until granted
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(ifa.req_en[i] && a_wprev != i)) begin
                    ifa.req_en[i]    = 1'($urandom_range(0, 1));
                    ifa.req_wr[i]    = 1'($urandom_range(0, 1));
                    ifa.req_addr[i]  = 6'($urandom_range(0, 7));
                    ifa.req_wdata[i] = $urandom;
                end
            end
            cyc_a();
        end
        ifa.req_en = 2'b00;
        repeat (2) cyc_a();

        // NREQ=3 fairness
        b_last = 2; b_pend = -1; b_cnt = 0;
        for (int i = 0; i < 3; i++) tally[i] = 0;
        ifb.req_en = 3'b111; ifb.req_wr = 3'b000;
        rst_b = 1'b0;
        repeat (9) cyc_b();
        for (int i = 0; i < 3; i++) chk($sformatf("t5_tally%0d", i), 64'(tally[i]), 64'd3);
        ifb.req_en = 3'b101;
        repeat (6) cyc_b();
        chk("t5_tally1_dropped", 64'(tally[1]), 64'd3);
        chk("t5_tally2", 64'(tally[2]), 64'd6);

        // conflict counter saturation
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("t6_rst_cnt", 64'(ifb.conflict_cnt), 0);
        ifb.req_en = 3'b011;
        rst_b = 1'b0;
        repeat (65534) @(posedge clk);
        #1 chk("t6_fffe", 64'(ifb.conflict_cnt), 64'hFFFE);
        @(posedge clk);
        #1 chk("t6_ffff", 64'(ifb.conflict_cnt), 64'hFFFF);
        repeat (100) @(posedge clk);
        #1 chk("t6_hold", 64'(ifb.conflict_cnt), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
